// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and byte-enable helper shared by the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;
    // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word
    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
        return (funct3[1:0] == 2'b00) ? 4'b0001 << off :
               (funct3[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication and load extract/extend for a 32-bit data bus.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_sh;
    always_comb begin
        w_sh    = i_rdata >> {i_off, 3'b000};
        // replication puts the byte/half on every lane, so byte enables alone select the target
        o_wdata = (i_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}} :
                  (i_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = (i_funct3 == F3_B)  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                  (i_funct3 == F3_H)  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                  (i_funct3 == F3_BU) ? {24'b0, w_sh[7:0]} :
                  (i_funct3 == F3_HU) ? {16'b0, w_sh[15:0]} : w_sh;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a req/gnt/rvalid data bus; non-memory ops pass through.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of forcing alignment.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_load,
    input  logic                i_store,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_data,
    output logic                o_err,
    output logic                o_mem_req,
    input  logic                i_mem_gnt,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0]   o_mem_be,
    output logic [XLEN-1:0]     o_mem_wdata,
    input  logic                i_mem_rvalid,
    input  logic [XLEN-1:0]     i_mem_rdata
);
    lsu_state_e        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we, r_err;
    logic [XLEN-1:0]   r_wdata, r_data, w_ld_data;
    logic [15:0]       r_cnt;
    logic              w_mem, w_f3_ok, w_mis, w_go, w_to, w_busy;
    logic [1:0]        w_off;

    always_comb begin
        w_mem   = i_load | i_store;
        w_f3_ok = (i_funct3 == F3_B) | (i_funct3 == F3_H) | (i_funct3 == F3_W) |
                  (i_load & ((i_funct3 == F3_BU) | (i_funct3 == F3_HU)));
        w_mis   = ((i_funct3[1:0] == 2'b01) & i_addr[0]) | ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        w_go    = w_f3_ok & ~w_mis;
`else
        w_go    = w_f3_ok;
`endif
        w_off   = (i_funct3[1:0] == 2'b01) ? {i_addr[1], 1'b0} :
                  (i_funct3[1:0] == 2'b10) ? 2'b00 : i_addr[1:0];
        w_busy  = (r_state == S_REQ) | (r_state == S_WAIT);
        w_to    = (TIMEOUT_CYC != 0) && (r_cnt == 16'(TIMEOUT_CYC - 1));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = i_valid ? ((w_mem & w_go) ? S_REQ : S_RESP) : S_IDLE;
            S_REQ:   w_next = w_to ? S_RESP : i_mem_gnt ? S_WAIT : S_REQ;
            S_WAIT:  w_next = (i_mem_rvalid | w_to) ? S_RESP : S_WAIT;
            default: w_next = i_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
            if (r_state == S_IDLE && i_valid) begin
                r_addr  <= {i_addr[ADDR_W-1:2], w_off};
                r_f3    <= i_funct3;
                r_we    <= i_store;
                r_wdata <= i_wdata;
                r_data  <= w_mem ? '0 : XLEN'(i_addr);
                r_err   <= w_mem & ~w_go;
            end else if (r_state == S_WAIT && i_mem_rvalid) begin
                r_data <= r_we ? '0 : w_ld_data;
            end else if (w_busy && w_to) begin
                r_err <= 1'b1;
            end
        end
    end

    lsu_align u_align (
        .i_funct3 (r_f3),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (i_mem_rdata),
        .o_wdata  (o_mem_wdata),
        .o_rdata  (w_ld_data)
    );

    assign o_ready    = r_state == S_IDLE;
    assign o_valid    = r_state == S_RESP;
    assign o_mem_req  = r_state == S_REQ;
    assign o_mem_we   = o_mem_req & r_we;
    assign o_mem_be   = o_mem_req ? be_gen(r_f3, r_addr[1:0]) : '0;
    assign o_mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_data     = r_data;
    assign o_err      = r_err;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized load/store/passthrough ops against a byte-level memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;
    logic        clk = 0, rst_n = 0, valid = 0, load = 0, store = 0, oready = 0, gnt = 0, rvalid = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0, wdata = 0, rdata = 0;
    logic        o_ready, o_valid, o_err, o_mem_req, o_mem_we;
    logic [31:0] o_data, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic [31:0] mem [0:255];
    logic [31:0] last_data, last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_err;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_load(load), .i_store(store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_valid(o_valid), .i_ready(oready), .o_data(o_data), .o_err(o_err),
        .o_mem_req(o_mem_req), .i_mem_gnt(gnt), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected bus access and result from access size/alignment arithmetic over the byte memory.
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  output bit bus, output logic [31:0] ea, output logic [3:0] eb,
                                  output int off, output logic [31:0] ed, output logic ee);
        int sz;
        longint v;
        bus = 0; ea = 0; eb = 0; off = 0; ed = 0; ee = 0;
        if (!ld && !st) begin
            ed = a;
            return;
        end
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (ld && (f3 == 3'd4 || f3 == 3'd5)))) begin
            ee = 1;
            return;
        end
        sz = 1 << f3[1:0];
        if (a % sz != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            ee = 1;
            return;
`else
            a = a - a % sz;
`endif
        end
        off = int'(a % 4);
        bus = 1;
        ea  = a - off;
        eb  = 4'(((1 << sz) - 1) << off);
        if (ld) begin
            v = 0;
            for (int i = 0; i < sz; i++) v += longint'(mem[ea[9:2]][8*(off+i) +: 8]) << (8*i);
            if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1))) v -= longint'(1) << (8*sz);
            ed = v[31:0];
        end
    endfunction

    task automatic op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int d1, input int d2, input int rd);
        bit bus;
        logic [31:0] ea, ed;
        logic [3:0] eb;
        logic ee;
        int off;
        model(ld, st, f3, a, bus, ea, eb, off, ed, ee);
        last_be = 0; last_wdata = 0; last_addr = 0;
        @(negedge clk);
        chk("in_ready_idle", 32'(o_ready), 32'd1);
        valid = 1; load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        valid = 0; load = 0; store = 0; addr = $urandom; wdata = $urandom;
        if (bus) begin
            for (int k = 0; k <= d1; k++) begin
                chk("mem_req", 32'(o_mem_req), 32'd1);
                chk("mem_addr", o_mem_addr, ea);
                chk("mem_be", 32'(o_mem_be), 32'(eb));
                chk("mem_we", 32'(o_mem_we), 32'(st));
                chk("out_valid_req", 32'(o_valid), 32'd0);
                if (st)
                    for (int l = 0; l < 4; l++)
                        if (eb[l]) chk("mem_wdata_lane", 32'(o_mem_wdata[8*l +: 8]), 32'(wd[8*(l-off) +: 8]));
                last_be = o_mem_be; last_wdata = o_mem_wdata; last_addr = o_mem_addr;
                gnt = (k == d1);
                @(negedge clk);
                gnt = 0;
            end
            for (int j = 0; j <= d2; j++) begin
                chk("mem_req_wait", 32'(o_mem_req), 32'd0);
                chk("out_valid_wait", 32'(o_valid), 32'd0);
                rvalid = (j == d2);
                rdata = (rvalid && ld) ? mem[ea[9:2]] : $urandom;
                @(negedge clk);
                rvalid = 0;
            end
            if (st)
                for (int l = 0; l < 4; l++)
                    if (eb[l]) mem[ea[9:2]][8*l +: 8] = wd[8*(l-off) +: 8];
        end else begin
            chk("mem_req_none", 32'(o_mem_req), 32'd0);
        end
        last_data = o_data; last_err = o_err;
        for (int r = 0; r <= rd; r++) begin
            chk("out_valid", 32'(o_valid), 32'd1);
            chk("out_data", o_data, ed);
            chk("out_err", 32'(o_err), 32'(ee));
            chk("in_ready_resp", 32'(o_ready), 32'd0);
            oready = (r == rd);
            @(negedge clk);
            oready = 0;
        end
        chk("out_valid_drop", 32'(o_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        chk("rst_be", 32'(o_mem_be), 32'd0);
        @(negedge clk);
        rst_n = 1;

        op(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 0, 0, 0);
        chk("t1_be", 32'(last_be), 32'hF);
        chk("t1_addr", last_addr, 32'h100);
        chk("t1_data", last_data, 32'h0);

        mem[32'h200 >> 2] = 32'h8081_7F80;
        op(1, 0, F3_B, 32'h201, 0, 0, 0, 0);
        chk("t2_lb_201", last_data, 32'h0000007F);
        op(1, 0, F3_B, 32'h200, 0, 0, 0, 0);
        chk("t2_lb_200", last_data, 32'hFFFFFF80);
        op(1, 0, F3_HU, 32'h202, 0, 0, 0, 0);
        chk("t2_lhu_202", last_data, 32'h00008081);
        op(1, 0, F3_H, 32'h202, 0, 0, 0, 0);
        chk("t2_lh_202", last_data, 32'hFFFF8081);

        op(0, 1, F3_B, 32'h303, 32'h000000AB, 5, 0, 0);
        chk("t3_be", 32'(last_be), 32'h8);
        chk("t3_lane3", 32'(last_wdata[31:24]), 32'hAB);

        op(1, 0, F3_W, 32'h102, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("t4_err", 32'(last_err), 32'd1);
`else
        chk("t4_addr", last_addr, 32'h100);
        chk("t4_err", 32'(last_err), 32'd0);
`endif

        op(1, 0, 3'b011, 32'h104, 0, 0, 0, 0);
        chk("unknown_f3_err", 32'(last_err), 32'd1);
        op(0, 0, 3'b000, 32'h1234_5678, 0, 0, 0, 0);
        chk("passthrough", last_data, 32'h1234_5678);

        // bus timeout: granted load never answered
        @(negedge clk);
        valid = 1; load = 1; funct3 = F3_W; addr = 32'h40;
        @(negedge clk);
        valid = 0; load = 0;
        for (int k = 0; k < 8; k++) begin
            chk("to_pending", 32'(o_valid), 32'd0);
            gnt = (k == 0);
            @(negedge clk);
            gnt = 0;
        end
        for (int k = 0; k < 3; k++) begin
            chk("to_valid", 32'(o_valid), 32'd1);
            chk("to_err", 32'(o_err), 32'd1);
            chk("to_data", o_data, 32'd0);
            rvalid = 1; rdata = 32'hFFFF_FFFF;
            oready = (k == 2);
            @(negedge clk);
            oready = 0;
        end
        chk("to_idle_stray", 32'(o_valid), 32'd0);
        @(negedge clk);
        rvalid = 0;
        chk("to_idle_quiet", 32'(o_valid), 32'd0);
        op(1, 0, F3_W, 32'h44, 0, 0, 1, 0);

        op(1, 0, F3_W, 32'h48, 0, 0, 0, 4);

        // reset asserted while waiting for read data
        @(negedge clk);
        valid = 1; load = 1; funct3 = F3_W; addr = 32'h4C;
        @(negedge clk);
        valid = 0; load = 0; gnt = 1;
        @(negedge clk);
        gnt = 0; rst_n = 0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(o_ready), 32'd1);
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_data", o_data, 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        chk("mid_rst_req", 32'(o_mem_req), 32'd0);
        chk("mid_rst_be", 32'(o_mem_be), 32'd0);
        rst_n = 1;
        op(0, 1, F3_H, 32'h50, 32'h0000BEEF, 1, 0, 0);

        for (int n = 0; n < 60; n++) begin
            int sel;
            logic [2:0] f3;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) + 1) % 5 == 0 ? 0 : 0);
                case ($urandom_range(0, 4))
                    0: f3 = F3_B;
                    1: f3 = F3_H;
                    2: f3 = F3_W;
                    3: f3 = F3_BU;
                    default: f3 = F3_HU;
                endcase
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
                op(1, 0, f3, 32'($urandom_range(0, 1023)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            end else if (sel < 8) begin
                f3 = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
                op(0, 1, f3, 32'($urandom_range(0, 1023)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                op(0, 0, 3'($urandom), $urandom, $urandom, 0, 0, $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
